pwm_ctrl_multi: RTL and testbench

Multi-channel PWM generator with button-driven duty adjustment.
- A shared prescaler and a WIDTH-bit period counter drive CH independent PWM outputs.
- Each channel has its own duty register. Up/down/next buttons (active-low, asynchronous inputs) select a channel and step its duty.
- The duty step law is geometric or linear, chosen by parameter.
- Duty changes are shadowed and take effect only at period boundaries, so no output glitches.

---
 rtl/pwm_ctrl_multi.sv | 176 +++++++++++++++++
 tb/tb_pwm_ctrl_multi.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_ctrl_multi.sv
// Multi-channel PWM generator with button-driven duty adjustment.
// A shared prescaler and period counter drive CH outputs. Each channel keeps a
// live duty register edited by the buttons and a shadow copy used for compare,
// refreshed only at the period wrap so edits never truncate a running pulse.
module pwm_ctrl_multi #(
  parameter int CH       = 4,
  parameter int WIDTH    = 8,
  parameter int PRESC    = 10,
  parameter int KEY      = 5000000,
  parameter int MODE     = 0,
  parameter int STEP     = 1,
  parameter int DUTY_RST = 1,
  localparam int SELW    = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up,
  input  logic             down,
  input  logic             nxt,
  output logic [CH-1:0]    pwm,
  output logic [WIDTH-1:0] state,
  output logic [SELW-1:0]  sel,
  output logic             period_start
);

  localparam int PW = (PRESC > 0) ? $clog2(PRESC + 1) : 1;
  localparam int KW = (KEY > 0) ? $clog2(KEY + 1) : 1;

  localparam logic [PW-1:0]    PRE_MAX   = PW'(PRESC);
  localparam logic [KW-1:0]    KEY_MAX   = KW'(KEY);
  localparam logic [WIDTH-1:0] DUTY_INIT = WIDTH'(DUTY_RST);
  localparam logic [WIDTH:0]   STEP_W    = (WIDTH + 1)'(STEP);
  localparam logic [WIDTH:0]   DUTY_MAX  = {1'b0, {WIDTH{1'b1}}};
  localparam logic [SELW-1:0]  SEL_LAST  = SELW'(CH - 1);

  typedef enum logic [1:0] {
    ACT_NONE,
    ACT_UP,
    ACT_DOWN,
    ACT_NEXT
  } act_t;

  logic [PW-1:0]    pre;
  logic             tick;
  logic [WIDTH-1:0] tim;
  logic             wrap;
  logic [KW-1:0]    keycnt;
  logic             key_tick;

  logic [1:0]       up_sync;
  logic [1:0]       down_sync;
  logic [1:0]       nxt_sync;

  logic [WIDTH-1:0] duty     [CH];
  logic [WIDTH-1:0] duty_act [CH];

  act_t             act;
  logic [WIDTH-1:0] duty_sel;
  logic [WIDTH-1:0] duty_inc;
  logic [WIDTH-1:0] duty_dec;
  logic [WIDTH:0]   sum;

  assign tick     = (pre == PRE_MAX);
  assign wrap     = (tim == '1);
  assign key_tick = (keycnt == KEY_MAX);
  assign duty_sel = duty[sel];
  assign state    = ~duty_sel;

  // Prescaler: one carrier tick every PRESC+1 clocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre <= '0;
    end else if (tick) begin
      pre <= '0;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  // Period counter, shadow duty load at wrap, and registered PWM compare.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tim          <= '0;
      period_start <= 1'b0;
      pwm          <= '0;
      for (int unsigned i = 0; i < CH; i++) begin
        duty_act[i] <= DUTY_INIT;
      end
    end else begin
      period_start <= tick && wrap;
      if (tick) begin
        tim <= tim + 1'b1;
        for (int unsigned i = 0; i < CH; i++) begin
          pwm[i] <= (tim < duty_act[i]);
        end
        if (wrap) begin
          for (int unsigned i = 0; i < CH; i++) begin
            duty_act[i] <= duty[i];
          end
        end
      end
    end
  end

  // Button step interval counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      keycnt <= '0;
    end else if (key_tick) begin
      keycnt <= '0;
    end else begin
      keycnt <= keycnt + 1'b1;
    end
  end

  // Two-flop synchronizers for the asynchronous active-low buttons.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      up_sync   <= '1;
      down_sync <= '1;
      nxt_sync  <= '1;
    end else begin
      up_sync   <= {up_sync[0], up};
      down_sync <= {down_sync[0], down};
      nxt_sync  <= {nxt_sync[0], nxt};
    end
  end

  // Pick at most one action per step tick, priority up > down > nxt.
  always_comb begin
    act = ACT_NONE;
    if (key_tick) begin
      if (!up_sync[1]) begin
        act = ACT_UP;
      end else if (!down_sync[1]) begin
        act = ACT_DOWN;
      end else if (!nxt_sync[1]) begin
        act = ACT_NEXT;
      end
    end
  end

  // Candidate duty values for the selected channel under the chosen step law.
  always_comb begin
    duty_inc = duty_sel;
    duty_dec = duty_sel;
    sum      = '0;
    if (MODE == 0) begin
      duty_inc = (duty_sel << 1) | WIDTH'(1);
      duty_dec = (duty_sel >> 1) | WIDTH'(1);
    end else begin
      // One extra bit keeps the increment from wrapping before saturation.
      sum      = {1'b0, duty_sel} + STEP_W;
      duty_inc = (sum > DUTY_MAX) ? '1 : sum[WIDTH-1:0];
      duty_dec = ({1'b0, duty_sel} < STEP_W) ? '0 : (duty_sel - STEP_W[WIDTH-1:0]);
    end
  end

  // Live duty registers and channel selection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel <= '0;
      for (int unsigned i = 0; i < CH; i++) begin
        duty[i] <= DUTY_INIT;
      end
    end else begin
      case (act)
        ACT_UP:   duty[sel] <= duty_inc;
        ACT_DOWN: duty[sel] <= duty_dec;
        ACT_NEXT: sel <= (sel == SEL_LAST) ? '0 : (sel + 1'b1);
        default:  ;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_ctrl_multi.sv
// Bench for pwm_ctrl_multi: a geometric-step instance and a linear-step
// instance share clock and reset. Expected duties are queued when a button is
// pressed and compared against state after each step interval.
module tb_pwm_ctrl_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic       up, down, nxt;
  logic [1:0] pwm;
  logic [3:0] state;
  logic [0:0] sel;
  logic       period_start;
  logic       up_b, down_b, nxt_b;
  logic [1:0] pwm_b;
  logic [3:0] state_b;
  logic [0:0] sel_b;
  logic       period_start_b;

  int checks = 0;
  int errors = 0;
  int cyc;
  logic [3:0] exp_q[$];

  pwm_ctrl_multi #(
    .CH(2), .WIDTH(4), .PRESC(1), .KEY(3), .MODE(0), .STEP(1), .DUTY_RST(1)
  ) dut (
    .clk(clk), .rst(rst), .up(up), .down(down), .nxt(nxt),
    .pwm(pwm), .state(state), .sel(sel), .period_start(period_start)
  );

  pwm_ctrl_multi #(
    .CH(2), .WIDTH(4), .PRESC(1), .KEY(3), .MODE(1), .STEP(4), .DUTY_RST(0)
  ) dut_lin (
    .clk(clk), .rst(rst), .up(up_b), .down(down_b), .nxt(nxt_b),
    .pwm(pwm_b), .state(state_b), .sel(sel_b), .period_start(period_start_b)
  );

  always #5 clk = ~clk;

  // Clocks elapsed since reset release; step ticks land on multiples of 4.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic step_clk;
    @(posedge clk);
    #1;
  endtask

  task automatic run_step;
    repeat (4) step_clk();
  endtask

  task automatic apply_reset;
    rst = 1'b1;
    up = 1'b1; down = 1'b1; nxt = 1'b1;
    up_b = 1'b1; down_b = 1'b1; nxt_b = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic align_step;
    int g;
    g = 0;
    step_clk();
    while ((cyc % 4) != 0 && g < 8) begin
      step_clk();
      g++;
    end
  endtask

  task automatic test_reset;
    up = 1'b1; down = 1'b1; nxt = 1'b1;
    up_b = 1'b1; down_b = 1'b1; nxt_b = 1'b1;
    rst = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    checks++; if (pwm !== 2'b00) begin errors++; $display("FAIL reset_pwm: got %b expected 00", pwm); end
    checks++; if (period_start !== 1'b0) begin errors++; $display("FAIL reset_period_start: got %b expected 0", period_start); end
    checks++; if (sel !== 1'b0) begin errors++; $display("FAIL reset_sel: got %b expected 0", sel); end
    checks++; if (state !== 4'b1110) begin errors++; $display("FAIL reset_state: got %b expected 1110", state); end
    checks++; if (state_b !== 4'b1111) begin errors++; $display("FAIL reset_state_lin: got %b expected 1111", state_b); end
    checks++; if (pwm_b !== 2'b00) begin errors++; $display("FAIL reset_pwm_lin: got %b expected 00", pwm_b); end
  endtask

  task automatic test_idle;
    int n, hi0, hi1, hib, ps;
    apply_reset();
    n = 0;
    while (!period_start && n < 64) begin
      step_clk();
      n++;
    end
    checks++; if (n != 32) begin errors++; $display("FAIL idle_first_wrap: got %0d clk expected 32", n); end
    hi0 = int'(pwm[0]); hi1 = int'(pwm[1]); hib = int'(pwm_b != 2'b00); ps = int'(period_start);
    repeat (31) begin
      step_clk();
      hi0 += int'(pwm[0]); hi1 += int'(pwm[1]); hib += int'(pwm_b != 2'b00); ps += int'(period_start);
    end
    checks++; if (hi0 != 2) begin errors++; $display("FAIL idle_pwm0_high: got %0d expected 2", hi0); end
    checks++; if (hi1 != 2) begin errors++; $display("FAIL idle_pwm1_high: got %0d expected 2", hi1); end
    checks++; if (hib != 0) begin errors++; $display("FAIL idle_lin_pwm_high: got %0d expected 0", hib); end
    checks++; if (ps != 1) begin errors++; $display("FAIL idle_ps_pulses: got %0d expected 1", ps); end
    step_clk();
    checks++; if (period_start !== 1'b1) begin errors++; $display("FAIL idle_second_wrap: got %b expected 1", period_start); end
    checks++; if (state !== 4'b1110) begin errors++; $display("FAIL idle_state: got %b expected 1110", state); end
  endtask

  task automatic test_up_geo;
    int n, hi_early, hi0, hi1;
    logic [3:0] e;
    apply_reset();
    align_step();
    exp_q.push_back(4'd3); exp_q.push_back(4'd7); exp_q.push_back(4'd15);
    exp_q.push_back(4'd15); exp_q.push_back(4'd15);
    up = 1'b0;
    hi_early = 0;
    for (int i = 0; i < 5; i++) begin
      repeat (4) begin
        step_clk();
        hi_early += int'(pwm[0]);
      end
      e = exp_q.pop_front();
      checks++; if (state !== ~e) begin errors++; $display("FAIL up_geo_state[%0d]: got %b expected %b", i, state, ~e); end
    end
    up = 1'b1;
    checks++; if (sel !== 1'b0) begin errors++; $display("FAIL up_geo_sel: got %b expected 0", sel); end
    n = 0;
    while (!period_start && n < 64) begin
      step_clk();
      n++;
      if (!period_start) hi_early += int'(pwm[0]);
    end
    checks++; if (cyc != 32) begin errors++; $display("FAIL up_geo_wrap_cycle: got %0d expected 32", cyc); end
    checks++; if (hi_early != 0) begin errors++; $display("FAIL up_geo_pwm_before_wrap: got %0d high clk expected 0", hi_early); end
    hi0 = int'(pwm[0]); hi1 = int'(pwm[1]);
    repeat (31) begin
      step_clk();
      hi0 += int'(pwm[0]); hi1 += int'(pwm[1]);
    end
    checks++; if (hi0 != 30) begin errors++; $display("FAIL up_geo_pwm0_high: got %0d expected 30", hi0); end
    checks++; if (hi1 != 2) begin errors++; $display("FAIL up_geo_pwm1_high: got %0d expected 2", hi1); end
  endtask

  task automatic test_down_geo;
    logic [3:0] e;
    align_step();
    exp_q.push_back(4'd7); exp_q.push_back(4'd3); exp_q.push_back(4'd1); exp_q.push_back(4'd1);
    down = 1'b0;
    for (int i = 0; i < 4; i++) begin
      run_step();
      e = exp_q.pop_front();
      checks++; if (state !== ~e) begin errors++; $display("FAIL down_geo_state[%0d]: got %b expected %b", i, state, ~e); end
    end
    down = 1'b1;
  endtask

  task automatic test_nxt;
    logic [3:0] e;
    exp_q.push_back(4'd1);
    nxt = 1'b0;
    run_step();
    nxt = 1'b1;
    e = exp_q.pop_front();
    checks++; if (sel !== 1'b1) begin errors++; $display("FAIL nxt_sel1: got %b expected 1", sel); end
    checks++; if (state !== ~e) begin errors++; $display("FAIL nxt_state_ch1: got %b expected %b", state, ~e); end
    exp_q.push_back(4'd3);
    up = 1'b0;
    run_step();
    up = 1'b1;
    e = exp_q.pop_front();
    checks++; if (state !== ~e) begin errors++; $display("FAIL nxt_up_ch1: got %b expected %b", state, ~e); end
    checks++; if (sel !== 1'b1) begin errors++; $display("FAIL nxt_up_sel: got %b expected 1", sel); end
    exp_q.push_back(4'd1);
    nxt = 1'b0;
    run_step();
    nxt = 1'b1;
    e = exp_q.pop_front();
    checks++; if (sel !== 1'b0) begin errors++; $display("FAIL nxt_wrap_sel: got %b expected 0", sel); end
    checks++; if (state !== ~e) begin errors++; $display("FAIL nxt_ch0_untouched: got %b expected %b", state, ~e); end
  endtask

  task automatic test_priority;
    logic [3:0] e;
    exp_q.push_back(4'd3);
    up = 1'b0; down = 1'b0;
    run_step();
    up = 1'b1; down = 1'b1;
    e = exp_q.pop_front();
    checks++; if (state !== ~e) begin errors++; $display("FAIL prio_up_down: got %b expected %b", state, ~e); end
    exp_q.push_back(4'd7);
    up = 1'b0; nxt = 1'b0;
    run_step();
    up = 1'b1; nxt = 1'b1;
    e = exp_q.pop_front();
    checks++; if (state !== ~e) begin errors++; $display("FAIL prio_up_nxt_state: got %b expected %b", state, ~e); end
    checks++; if (sel !== 1'b0) begin errors++; $display("FAIL prio_up_nxt_sel: got %b expected 0", sel); end
    exp_q.push_back(4'd3);
    down = 1'b0; nxt = 1'b0;
    run_step();
    down = 1'b1; nxt = 1'b1;
    e = exp_q.pop_front();
    checks++; if (state !== ~e) begin errors++; $display("FAIL prio_down_nxt_state: got %b expected %b", state, ~e); end
    checks++; if (sel !== 1'b0) begin errors++; $display("FAIL prio_down_nxt_sel: got %b expected 0", sel); end
  endtask

  task automatic test_linear;
    int hib;
    logic [3:0] e;
    apply_reset();
    align_step();
    exp_q.push_back(4'd4); exp_q.push_back(4'd8); exp_q.push_back(4'd12);
    exp_q.push_back(4'd15); exp_q.push_back(4'd15);
    up_b = 1'b0;
    hib = 0;
    for (int i = 0; i < 5; i++) begin
      repeat (4) begin
        step_clk();
        hib += int'(pwm_b != 2'b00);
      end
      e = exp_q.pop_front();
      checks++; if (state_b !== ~e) begin errors++; $display("FAIL lin_up_state[%0d]: got %b expected %b", i, state_b, ~e); end
    end
    up_b = 1'b1;
    checks++; if (hib != 0) begin errors++; $display("FAIL lin_pwm_low: got %0d high clk expected 0", hib); end
    exp_q.push_back(4'd11); exp_q.push_back(4'd7); exp_q.push_back(4'd3);
    exp_q.push_back(4'd0); exp_q.push_back(4'd0);
    down_b = 1'b0;
    for (int i = 0; i < 5; i++) begin
      run_step();
      e = exp_q.pop_front();
      checks++; if (state_b !== ~e) begin errors++; $display("FAIL lin_down_state[%0d]: got %b expected %b", i, state_b, ~e); end
    end
    down_b = 1'b1;
    checks++; if (state !== 4'b1110) begin errors++; $display("FAIL lin_geo_isolated: got %b expected 1110", state); end
  endtask

  task automatic test_async_reset;
    int n;
    apply_reset();
    align_step();
    up = 1'b0;
    run_step();
    run_step();
    up = 1'b1;
    checks++; if (state !== 4'b1000) begin errors++; $display("FAIL arst_pre_state: got %b expected 1000", state); end
    n = 0;
    while (cyc < 36 && n < 64) begin
      step_clk();
      n++;
    end
    checks++; if (pwm !== 2'b01) begin errors++; $display("FAIL arst_pwm_before: got %b expected 01", pwm); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (pwm !== 2'b00) begin errors++; $display("FAIL arst_pwm_low: got %b expected 00", pwm); end
    checks++; if (state !== 4'b1110) begin errors++; $display("FAIL arst_duty_restored: got %b expected 1110", state); end
    checks++; if (sel !== 1'b0) begin errors++; $display("FAIL arst_sel: got %b expected 0", sel); end
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (!period_start && n < 64) begin
      step_clk();
      n++;
    end
    checks++; if (n != 32) begin errors++; $display("FAIL arst_first_wrap: got %0d clk expected 32", n); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_idle();
    test_up_geo();
    test_down_geo();
    test_nxt();
    test_priority();
    test_linear();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
